// File: rtl/pin_io_pkg.sv
// Shared constants and FSM state type for the board pin-input blocks.
// Pure declarations: no logic, no latency, no flow control.
package pin_io_pkg;

    localparam int OSC_HZ   = 2080000;
    localparam int DEB_10MS = OSC_HZ / 100;

    // Bit 1 of each encoding equals the debounced level in that state.
    typedef enum logic [1:0] {
        STABLE_LOW  = 2'b00,
        PEND_HIGH   = 2'b01,
        STABLE_HIGH = 2'b11,
        PEND_LOW    = 2'b10
    } deb_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, synchronous active-low reset to 0.
// Latency 2 cycles; no backpressure (free-running sampler).
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/pin_input_debouncer.sv
// Synchronise, debounce and edge-detect one board pin; optional press counter (PIN_DEBOUNCE_PRESS_COUNT_EN).
// Latency pin->level STABLE_CYCLES+2 cycles; no backpressure, all outputs registered.
module pin_input_debouncer
    import pin_io_pkg::*;
#(
    parameter int STABLE_CYCLES = DEB_10MS,
    parameter int CNT_W         = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pin,
    output logic       level,
    output logic       rise,
    output logic       fall
`ifdef PIN_DEBOUNCE_PRESS_COUNT_EN
    ,
    output logic [7:0] press_count
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             pin_s;
    deb_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             rise_event;
    logic             fall_event;

    sync_2ff #(
        .WIDTH(1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pin),
        .q     (pin_s)
    );

    // Terminal compare comes before any increment, so cnt never reaches 2^CNT_W.
    assign rise_event = (state == PEND_HIGH) && pin_s  && (cnt == CNT_LAST);
    assign fall_event = (state == PEND_LOW)  && !pin_s && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= STABLE_LOW;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                STABLE_LOW: begin
                    if (pin_s) begin
                        state <= PEND_HIGH;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt   <= '0;
                    end
                end
                PEND_HIGH: begin
                    if (!pin_s) begin
                        state <= STABLE_LOW;
                        cnt   <= '0;
                    end else if (rise_event) begin
                        state <= STABLE_HIGH;
                        level <= 1'b1;
                        rise  <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt   <= cnt + CNT_ONE;
                    end
                end
                STABLE_HIGH: begin
                    if (!pin_s) begin
                        state <= PEND_LOW;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt   <= '0;
                    end
                end
                PEND_LOW: begin
                    if (pin_s) begin
                        state <= STABLE_HIGH;
                        cnt   <= '0;
                    end else if (fall_event) begin
                        state <= STABLE_LOW;
                        level <= 1'b0;
                        fall  <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt   <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= STABLE_LOW;
                    cnt   <= '0;
                    level <= 1'b0;
                end
            endcase
        end
    end

`ifdef PIN_DEBOUNCE_PRESS_COUNT_EN
    // Counts on the same edge that raises rise, so the count already includes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            press_count <= '0;
        end else if (rise_event) begin
            press_count <= press_count + 8'd1;
        end
    end
`else
    // Press counter absent: level/rise/fall are the only outputs.
`endif

endmodule

// File: tb/tb_pin_input_debouncer.sv
// Bench for pin_input_debouncer: vector table, corner sequences and random run-length model.
// Build with PIN_DEBOUNCE_PRESS_COUNT_EN defined to also check press_count.
module tb_pin_input_debouncer;

    localparam int STABLE = 4;

    logic clk;
    logic rst_n;
    logic pin;
    logic level;
    logic rise;
    logic fall;
`ifdef PIN_DEBOUNCE_PRESS_COUNT_EN
    logic [7:0] press_count;
    logic [7:0] m_pc;
`endif

    int checks   = 0;
    int failures = 0;
    int edge_no  = 0;
    int n_rise   = 0;
    int n_fall   = 0;

    // Reference: pin_s is pin delayed two edges; level toggles once pin_s has
    // disagreed with it on STABLE consecutive edges.
    logic m_s1, m_ps, m_level, m_rise, m_fall;
    int   m_run;

    pin_input_debouncer #(
        .STABLE_CYCLES(STABLE),
        .CNT_W        (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pin         (pin),
        .level       (level),
        .rise        (rise),
        .fall        (fall)
`ifdef PIN_DEBOUNCE_PRESS_COUNT_EN
        ,
        .press_count (press_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       p;
        logic       r;
        logic [2:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (edge %0d)", name, act, exp, edge_no);
        end
    endtask

    task automatic model_step(input logic p, input logic r);
        if (!r) begin
            m_s1 = 0; m_ps = 0; m_level = 0; m_rise = 0; m_fall = 0; m_run = 0;
`ifdef PIN_DEBOUNCE_PRESS_COUNT_EN
            m_pc = 8'd0;
`endif
        end else begin
            m_rise = 0;
            m_fall = 0;
            if (m_ps != m_level) m_run++;
            else                 m_run = 0;
            if (m_run == STABLE) begin
                m_level = !m_level;
                m_run   = 0;
                if (m_level) begin
                    m_rise = 1;
`ifdef PIN_DEBOUNCE_PRESS_COUNT_EN
                    m_pc = m_pc + 8'd1;
`endif
                end else begin
                    m_fall = 1;
                end
            end
            m_ps = m_s1;
            m_s1 = p;
        end
    endtask

    task automatic cycle(input logic p, input logic r);
        pin   = p;
        rst_n = r;
        @(posedge clk);
        model_step(p, r);
        #1;
        edge_no++;
        chk("model_outs", {29'd0, level, rise, fall}, {29'd0, m_level, m_rise, m_fall});
`ifdef PIN_DEBOUNCE_PRESS_COUNT_EN
        chk("model_press_count", {24'd0, press_count}, {24'd0, m_pc});
`endif
        if (rise === 1'b1) n_rise++;
        if (fall === 1'b1) n_fall++;
    endtask

    task automatic add(input logic p, input logic r, input logic [2:0] exp, input int n);
        vec_t v;
        v.p = p; v.r = r; v.exp = exp;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    initial begin
        int   rise_at;
        int   base;
        logic chat [9];

        pin = 1'b0;
        rst_n = 1'b0;
        m_s1 = 0; m_ps = 0; m_level = 0; m_rise = 0; m_fall = 0; m_run = 0;
`ifdef PIN_DEBOUNCE_PRESS_COUNT_EN
        m_pc = 8'd0;
`endif

        // exp = {level, rise, fall}
        add(0, 0, 3'b000, 2);
        add(0, 1, 3'b000, 20);
        add(1, 1, 3'b000, 5);
        add(1, 1, 3'b110, 1);
        add(1, 1, 3'b100, 3);
        add(0, 1, 3'b100, 5);
        add(0, 1, 3'b001, 1);
        add(0, 1, 3'b000, 2);
        add(1, 1, 3'b000, 1);
        add(0, 1, 3'b000, 8);
        add(1, 1, 3'b000, 3);
        add(0, 1, 3'b000, 8);

        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].p, tbl[i].r);
            chk($sformatf("vec%0d", i), {29'd0, level, rise, fall}, {29'd0, tbl[i].exp});
        end
        chk("table_rise_count", n_rise, 1);
        chk("table_fall_count", n_fall, 1);
`ifdef PIN_DEBOUNCE_PRESS_COUNT_EN
        chk("table_press_count", {24'd0, press_count}, 32'd1);
`endif

        // Chatter, then hold high: one rise, 5 edges after the sustained high begins at pin.
        chat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        base = n_rise;
        rise_at = -1;
        for (int j = 0; j < 20; j++) begin
            cycle((j < 9) ? chat[j] : 1'b1, 1'b1);
            if (rise === 1'b1 && rise_at < 0) rise_at = j;
        end
        chk("chatter_rise_count", n_rise - base, 1);
        chk("chatter_rise_edge", rise_at, 10);
        for (int j = 0; j < 10; j++) cycle(1'b0, 1'b1);
        chk("chatter_level_low", {31'd0, level}, 32'd0);

        // Reset at cnt=2 in PEND_HIGH, pin still high afterwards.
        base = n_rise;
        for (int j = 0; j < 4; j++) cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b0);
        chk("rst_mid_pend_outs", {29'd0, level, rise, fall}, 32'd0);
`ifdef PIN_DEBOUNCE_PRESS_COUNT_EN
        chk("rst_mid_pend_press", {24'd0, press_count}, 32'd0);
`endif
        chk("rst_mid_pend_no_strobe", n_rise - base, 0);
        rise_at = -1;
        for (int j = 0; j < 10; j++) begin
            cycle(1'b1, 1'b1);
            if (rise === 1'b1 && rise_at < 0) rise_at = j;
        end
        chk("rst_release_rise_edge", rise_at, 5);
        for (int j = 0; j < 12; j++) cycle(1'b0, 1'b1);

        // 256 clean presses from reset.
        cycle(1'b0, 1'b0);
        base = n_rise;
        rise_at = n_fall;
        for (int i = 0; i < 256; i++) begin
            for (int j = 0; j < 8; j++) cycle(1'b1, 1'b1);
            for (int j = 0; j < 8; j++) cycle(1'b0, 1'b1);
`ifdef PIN_DEBOUNCE_PRESS_COUNT_EN
            if (i == 254) chk("press_count_255", {24'd0, press_count}, 32'd255);
`endif
        end
        chk("presses_rise_count", n_rise - base, 256);
        chk("presses_fall_count", n_fall - rise_at, 256);
`ifdef PIN_DEBOUNCE_PRESS_COUNT_EN
        chk("press_count_wrap", {24'd0, press_count}, 32'd0);
`endif

        // Random run lengths around the debounce threshold, occasional reset.
        for (int k = 0; k < 600; k++) begin
            int   len;
            logic v;
            len = $urandom_range(1, 8);
            v   = 1'($urandom_range(0, 1));
            for (int j = 0; j < len; j++) begin
                cycle(v, ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1);
                chk("rise_fall_exclusive", {31'd0, rise & fall}, 32'd0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
